// File: rtl/pwr_switch_ack_emu.sv
// Power-switch acknowledge emulator: per-domain programmable on/off
// latency, abort on request reversal and a stall input for stuck switches.
module pwr_switch_ack_emu #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned LAT_W = 8,
  parameter int unsigned ON_LAT_RST = 15,
  parameter int unsigned OFF_LAT_RST = 15,
  parameter logic [NUM_DOMAINS-1:0] ACK_RST = '0,
  localparam int unsigned DOM_W =
    (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_DOMAINS-1:0] switch_i,
  input  logic [NUM_DOMAINS-1:0] stall_i,
  input  logic                   cfg_we_i,
  input  logic [DOM_W-1:0]       cfg_dom_i,
  input  logic [LAT_W-1:0]       cfg_on_lat_i,
  input  logic [LAT_W-1:0]       cfg_off_lat_i,
  output logic [NUM_DOMAINS-1:0] ack_o,
  output logic [NUM_DOMAINS-1:0] busy_o,
  output logic [NUM_DOMAINS-1:0] done_o
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  for (genvar d = 0; d < NUM_DOMAINS; d++) begin : g_dom
    state_e           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] on_lat_q;
    logic [LAT_W-1:0] off_lat_q;
    logic [LAT_W-1:0] lat_sel;
    logic [LAT_W-1:0] load_val;
    logic             ack_q;
    logic             busy_q;
    logic             fin_q;
    logic             done_q;
    logic             cfg_hit;

    // Zero latency behaves as one: the counter loads L-1.
    assign lat_sel  = switch_i[d] ? on_lat_q : off_lat_q;
    assign load_val = (lat_sel == '0) ? '0
                    : lat_sel - LAT_W'(1);
    assign cfg_hit  = cfg_we_i
                   && (cfg_dom_i == DOM_W'(d));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        on_lat_q  <= LAT_W'(ON_LAT_RST);
        off_lat_q <= LAT_W'(OFF_LAT_RST);
        ack_q     <= ACK_RST[d];
        busy_q    <= 1'b0;
        fin_q     <= 1'b0;
        done_q    <= 1'b0;
      end else begin
        fin_q  <= 1'b0;
        done_q <= fin_q;
        if (cfg_hit) begin
          on_lat_q  <= cfg_on_lat_i;
          off_lat_q <= cfg_off_lat_i;
        end
        case (state_q)
          IDLE: begin
            if (switch_i[d] != ack_q) begin
              state_q <= COUNT;
              busy_q  <= 1'b1;
              cnt_q   <= load_val;
            end
          end
          COUNT: begin
            priority case (1'b1)
              stall_i[d]: begin
                state_q <= COUNT;
              end
              (switch_i[d] == ack_q): begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
              (cnt_q != '0): begin
                cnt_q <= cnt_q - LAT_W'(1);
              end
              default: begin
                ack_q   <= switch_i[d];
                state_q <= IDLE;
                busy_q  <= 1'b0;
                fin_q   <= 1'b1;
              end
            endcase
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign ack_o[d]  = ack_q;
    assign busy_o[d] = busy_q;
    assign done_o[d] = done_q;
  end

endmodule
